// File: rtl/audio_sample_fifo.sv
// PCM sample FIFO: AXI4-Lite push/control slave feeding a 16-bit AXI-Stream master.
// Define AUDIO_FIFO_PACK_EN to push two 16-bit samples per 32-bit DATA write.
module audio_sample_fifo #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2     = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]                  S_AXI_awprot,
  input  logic                        S_AXI_awvalid,
  output logic                        S_AXI_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                        S_AXI_wvalid,
  output logic                        S_AXI_wready,
  output logic [1:0]                  S_AXI_bresp,
  output logic                        S_AXI_bvalid,
  input  logic                        S_AXI_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]                  S_AXI_arprot,
  input  logic                        S_AXI_arvalid,
  output logic                        S_AXI_arready,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]                  S_AXI_rresp,
  output logic                        S_AXI_rvalid,
  input  logic                        S_AXI_rready,
  output logic [15:0]                 M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        prog_empty
);
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_PACK, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d, thresh_q, thresh_d;
  logic                  ovf_q, ovf_d, udr_q, udr_d, prog_empty_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, status;
  logic [31:0]           thresh_wr;

  logic aw_hs, ar_hs, wr_data, wr_status, wr_thresh, flush;
  logic push, push_ok, pop, empty, full;
  logic [15:0] push_data;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  // Ready is offered combinationally in IDLE once address and data are both present.
  assign aw_hs     = aresetn && (wstate_q == W_IDLE) && S_AXI_awvalid && S_AXI_wvalid;
  assign wr_data   = aw_hs && (S_AXI_awaddr[4:2] == 3'd0);
  assign wr_status = aw_hs && (S_AXI_awaddr[4:2] == 3'd1);
  assign wr_thresh = aw_hs && (S_AXI_awaddr[4:2] == 3'd2);
  assign flush     = aw_hs && (S_AXI_awaddr[4:2] == 3'd3) && S_AXI_wdata[0];
  assign ar_hs     = S_AXI_arvalid && S_AXI_arready;

`ifdef AUDIO_FIFO_PACK_EN
  logic [15:0] pack_q;
  assign push      = wr_data || (wstate_q == W_PACK);
  assign push_data = (wstate_q == W_PACK) ? pack_q : S_AXI_wdata[15:0];
`else
  assign push      = wr_data;
  assign push_data = S_AXI_wdata[15:0];
`endif

  // A full FIFO never admits a push, even when a pop retires an entry that same cycle.
  assign push_ok = push && !full;
  assign pop     = M_AXIS_tready && !empty;

  always_comb begin
    thresh_wr = 32'(thresh_q);
    for (int b = 0; b < 4; b++)
      if (S_AXI_wstrb[b]) thresh_wr[8*b +: 8] = S_AXI_wdata[8*b +: 8];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    thresh_d = wr_thresh ? thresh_wr[LW-1:0] : thresh_q;
    ovf_d    = (ovf_q && !(wr_status && S_AXI_wdata[24])) || (push && full);
    udr_d    = (udr_q && !(wr_status && S_AXI_wdata[25])) || (M_AXIS_tready && empty);
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: if (aw_hs) begin
`ifdef AUDIO_FIFO_PACK_EN
        wstate_d = wr_data ? W_PACK : W_RESP;
`else
        wstate_d = W_RESP;
`endif
      end
      W_PACK:  wstate_d = W_RESP;
      W_RESP:  if (S_AXI_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (S_AXI_arvalid) rstate_d = R_DATA;
      R_DATA:  if (S_AXI_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    status         = '0;
    status[LW-1:0] = level_q;
    status[16]     = empty;
    status[17]     = full;
    status[24]     = ovf_q;
    status[25]     = udr_q;
    rdata_d        = '0;
    case (S_AXI_araddr[4:2])
      3'd1:    rdata_d = status;
      3'd2:    rdata_d[LW-1:0] = thresh_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      thresh_q     <= LW'(256);
      ovf_q        <= 1'b0;
      udr_q        <= 1'b0;
      prog_empty_q <= 1'b1;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      thresh_q     <= thresh_d;
      ovf_q        <= ovf_d;
      udr_q        <= udr_d;
      prog_empty_q <= (level_q <= thresh_q);
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
    if (ar_hs)   rdata_q <= rdata_d;
`ifdef AUDIO_FIFO_PACK_EN
    if (aw_hs)   pack_q <= S_AXI_wdata[31:16];
`endif
  end

  assign S_AXI_awready = aw_hs;
  assign S_AXI_wready  = aw_hs;
  assign S_AXI_bvalid  = (wstate_q == W_RESP);
  assign S_AXI_bresp   = 2'b00;
  assign S_AXI_arready = aresetn && (rstate_q == R_IDLE);
  assign S_AXI_rvalid  = (rstate_q == R_DATA);
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = 2'b00;
  assign M_AXIS_tdata  = mem[rd_ptr_q];
  assign M_AXIS_tvalid = !empty;
  assign prog_empty    = prog_empty_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_awaddr, S_AXI_araddr, S_AXI_awprot, S_AXI_arprot, thresh_wr};
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo (DEPTH_LOG2 = 10); pack-mode scenarios under AUDIO_FIFO_PACK_EN.
module tb_audio_sample_fifo;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1, tready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, tvalid, prog_empty;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] tdata;

  int checks = 0;
  int failures = 0;
  logic pe_at_b, tv_at_b;
  logic [15:0] got [0:2047];

  always #5 aclk = ~aclk;

  audio_sample_fifo #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .DEPTH_LOG2(10)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
    .M_AXIS_tdata(tdata), .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready), .prog_empty(prog_empty)
  );

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit pop);
    int n;
    @(posedge aclk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    if (pop) tready = 1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(posedge aclk); #1; n++; end
    if (!(awready && wready)) begin
      checks++; failures++;
      $display("FAIL aw_timeout addr=%h got awready=%b required=1", addr, awready);
    end
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    if (pop) tready = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    pe_at_b = prog_empty;
    tv_at_b = tvalid;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL bresp addr=%h got bvalid=%b bresp=%b required 1/00", addr, bvalid, bresp);
    end
    @(posedge aclk); #1;
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data);
    int n;
    @(posedge aclk); #1;
    araddr = addr; arvalid = 1; rready = 1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    data = rdata;
    checks++;
    if (rvalid !== 1'b1 || rresp !== 2'b00) begin
      failures++;
      $display("FAIL rresp addr=%h got rvalid=%b rresp=%b required 1/00", addr, rvalid, rresp);
    end
    @(posedge aclk); #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    @(posedge aclk); #1;
    while (tvalid && n < 2000) begin
      got[n] = tdata; n++;
      tready = 1;
      @(posedge aclk); #1;
    end
    tready = 0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    aresetn = 0;
    repeat (4) @(posedge aclk);
    #1;
    checks++;
    if ({awready, arready, bvalid, rvalid, tvalid, prog_empty} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_outputs got aw/ar/b/r/tv/pe=%b required 000001",
               {awready, arready, bvalid, rvalid, tvalid, prog_empty});
    end
    aresetn = 1; #1;
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL arready_after_reset got %b required 1", arready); end
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0001_0000) begin failures++; $display("FAIL reset_status got %h required 00010000", r); end
    axi_read(16'h08, r);
    checks++;
    if (r !== 32'd256) begin failures++; $display("FAIL reset_thresh got %0d required 256", r); end
  endtask

  task automatic test_ordering;
    logic [31:0] r;
    axi_write(16'h00, 32'h0000_1111, 4'hF, 0);
    axi_write(16'h00, 32'h0000_2222, 4'hF, 0);
    axi_write(16'h00, 32'h0000_3333, 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0000_0003) begin failures++; $display("FAIL order_level got %h required 00000003", r); end
    checks++;
    if (tvalid !== 1'b1 || tdata !== 16'h1111) begin
      failures++; $display("FAIL order_head got tv=%b data=%h required 1/1111", tvalid, tdata);
    end
    tready = 1;
    @(posedge aclk); #1;
    checks++;
    if (tdata !== 16'h2222) begin failures++; $display("FAIL order_second got %h required 2222", tdata); end
    @(posedge aclk); #1;
    checks++;
    if (tdata !== 16'h3333) begin failures++; $display("FAIL order_third got %h required 3333", tdata); end
    @(posedge aclk); #1;
    tready = 0;
    checks++;
    if (tvalid !== 1'b0) begin failures++; $display("FAIL order_tvalid_drop got %b required 0", tvalid); end
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0001_0000) begin failures++; $display("FAIL order_empty got %h required 00010000", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    axi_write(16'h00, 32'h0000_0A0A, 4'hF, 0);
    axi_write(16'h00, 32'hBBBB_0B0B, 4'hF, 1);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0000_0001) begin failures++; $display("FAIL pushpop_level got %h required 00000001", r); end
    checks++;
    if (tdata !== 16'h0B0B) begin failures++; $display("FAIL pushpop_head got %h required 0B0B", tdata); end
    tready = 1;
    @(posedge aclk); #1;
    tready = 0;
  endtask

  task automatic test_threshold;
    logic [31:0] r;
    axi_write(16'h08, 32'h0000_0002, 4'hF, 0);
    axi_write(16'h00, 32'h0000_0001, 4'hF, 0);
    axi_write(16'h00, 32'h0000_0002, 4'hF, 0);
    checks++;
    if (prog_empty !== 1'b1) begin failures++; $display("FAIL thr_level2 got %b required 1", prog_empty); end
    axi_write(16'h00, 32'h0000_0003, 4'hF, 0);
    checks++;
    if (pe_at_b !== 1'b1 || prog_empty !== 1'b0) begin
      failures++; $display("FAIL thr_fall got before/after=%b%b required 10", pe_at_b, prog_empty);
    end
    tready = 1;
    @(posedge aclk); #1;
    tready = 0;
    checks++;
    if (prog_empty !== 1'b0) begin failures++; $display("FAIL thr_rise_early got %b required 0", prog_empty); end
    @(posedge aclk); #1;
    checks++;
    if (prog_empty !== 1'b1) begin failures++; $display("FAIL thr_rise got %b required 1", prog_empty); end
    axi_write(16'h08, 32'hFFFF_FF55, 4'h1, 0);
    axi_write(16'h08, 32'hFFFF_03FF, 4'h2, 0);
    axi_read(16'h08, r);
    checks++;
    if (r !== 32'h0000_0355) begin failures++; $display("FAIL thr_strobe got %h required 00000355", r); end
    axi_write(16'h08, 32'h0000_0100, 4'hF, 0);
    tready = 1;
    repeat (2) @(posedge aclk);
    #1;
    tready = 0;
  endtask

  task automatic test_full_overflow;
    logic [31:0] r;
    int n, bad;
    for (int i = 0; i < 1024; i++) axi_write(16'h00, 32'(i), 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0002_0400) begin failures++; $display("FAIL full_status got %h required 00020400", r); end
    axi_write(16'h00, 32'h0000_DEAD, 4'hF, 1);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0100_03FF) begin failures++; $display("FAIL full_pushpop got %h required 010003FF", r); end
    axi_write(16'h00, 32'h0000_BEEF, 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0102_0400) begin failures++; $display("FAIL overflow_status got %h required 01020400", r); end
    axi_write(16'h04, 32'h0100_0000, 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0002_0400) begin failures++; $display("FAIL overflow_clear got %h required 00020400", r); end
    drain(n);
    checks++;
    if (n !== 1024) begin failures++; $display("FAIL full_drain_count got %0d required 1024", n); end
    bad = 0;
    for (int k = 0; k < 1023; k++) if (got[k] !== 16'(k + 1)) bad++;
    if (got[1023] !== 16'hBEEF) bad++;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL full_drain_data got %0d wrong entries required 0", bad); end
  endtask

  task automatic test_underrun_flush;
    logic [31:0] r;
    int n;
    tready = 1;
    @(posedge aclk); #1;
    tready = 0;
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0201_0000) begin failures++; $display("FAIL underrun_set got %h required 02010000", r); end
    for (int i = 0; i < 5; i++) axi_write(16'h00, 32'h50 + 32'(i), 4'hF, 0);
    axi_write(16'h0C, 32'h0000_0001, 4'hF, 0);
    checks++;
    if (tv_at_b !== 1'b0 || tvalid !== 1'b0) begin
      failures++; $display("FAIL flush_tvalid got %b%b required 00", tv_at_b, tvalid);
    end
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0201_0000) begin failures++; $display("FAIL flush_status got %h required 02010000", r); end
    axi_read(16'h0C, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL control_read got %h required 0", r); end
    axi_write(16'h00, 32'hBBBB_AAAA, 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0200_0001 || tdata !== 16'hAAAA) begin
      failures++; $display("FAIL upper_ignored got status=%h data=%h required 02000001/AAAA", r, tdata);
    end
    drain(n);
    axi_write(16'h04, 32'h0200_0000, 4'hF, 0);
    axi_write(16'h10, 32'h0000_0001, 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0001_0000) begin failures++; $display("FAIL underrun_clear got %h required 00010000", r); end
    axi_read(16'h00, r);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL data_read got %h required 0", r); end
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] r;
    axi_write(16'h00, 32'h0000_7777, 4'hF, 0);
    axi_write(16'h08, 32'h0000_0005, 4'hF, 0);
    @(posedge aclk); #1;
    araddr = 16'h04; arvalid = 1; rready = 0;
    @(posedge aclk); #1;
    arvalid = 0;
    @(posedge aclk); #1;
    checks++;
    if (rvalid !== 1'b1) begin failures++; $display("FAIL rvalid_hold got %b required 1", rvalid); end
    aresetn = 0;
    @(posedge aclk); #1;
    checks++;
    if ({rvalid, arready, tvalid} !== 3'b000) begin
      failures++; $display("FAIL mid_reset got rv/ar/tv=%b required 000", {rvalid, arready, tvalid});
    end
    aresetn = 1; rready = 1;
    axi_read(16'h08, r);
    checks++;
    if (r !== 32'd256) begin failures++; $display("FAIL mid_reset_thresh got %0d required 256", r); end
  endtask

`ifdef AUDIO_FIFO_PACK_EN
  task automatic test_pack;
    logic [31:0] r;
    int n;
    axi_write(16'h00, 32'hBBBB_AAAA, 4'hF, 0);
    drain(n);
    checks++;
    if (n !== 2 || got[0] !== 16'hAAAA || got[1] !== 16'hBBBB) begin
      failures++; $display("FAIL pack_order got n=%0d %h %h required 2 AAAA BBBB", n, got[0], got[1]);
    end
    for (int i = 0; i < 512; i++) axi_write(16'h00, 32'(i), 4'hF, 0);
    tready = 1;
    @(posedge aclk); #1;
    tready = 0;
    axi_write(16'h00, 32'hBBBB_AAAA, 4'hF, 0);
    axi_read(16'h04, r);
    checks++;
    if (r !== 32'h0102_0400) begin failures++; $display("FAIL pack_overflow got %h required 01020400", r); end
  endtask
`endif

  initial begin
    test_reset;
`ifdef AUDIO_FIFO_PACK_EN
    test_pack;
`else
    test_ordering;
    test_back_to_back;
    test_threshold;
    test_full_overflow;
    test_underrun_flush;
    test_reset_mid_read;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
